inst_prefetch: RTL and testbench
================================

# inst_prefetch

Byte-wide instruction prefetch and assembly unit for the 16-bit CPU. Fetches instruction bytes from the 8-bit program memory port into a parametrised byte queue, assembles 1- and 2-byte instructions into the 16-bit word format the instruction decoder consumes, and presents them with a valid/ready handshake. Supports branch/call redirect with queue flush. Sits between the memory interface and the decoder/execute stage.

## Interface

- DEPTH, 4, byte queue depth; power of two, ≥ 2
- ADDR_W, 16, program address width
- RESET_PC, 0, fetch address after reset

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- mem_req  out  1  fetch request
- mem_addr  out  ADDR_W  fetch address; stable while mem_req high
- mem_ack  in  1  byte returned; transfer occurs on edge where mem_req & mem_ack
- mem_data  in  8  fetched byte; valid with mem_ack
- redirect  in  1  flush queue and restart fetch
- redirect_pc  in  ADDR_W  new fetch address
- inst_valid  out  1  assembled instruction available
- inst_ready  in  1  consumer accepts; transfer on edge where inst_valid & inst_ready
- inst  out  16  instruction word: first byte in [15:8]; second byte in [7:0], or 0x00 for 1-byte instructions
- inst_bytes  out  2  1 or 2
- inst_pc  out  ADDR_W  address of first byte
- inst_zero_arg  out  1  inst[15] == 0
- inst_one_arg  out  1  inst[15:14] == 2'b10

## Operation

- State: circular byte queue (rd/wr pointers, count 0..DEPTH), fetch_pc, head_pc, run flag.
- Length rule: head byte bit 7 = 0 → 1-byte instruction; bit 7 = 1 → 2-byte.
- run resets 0, sets 1 on first edge after reset release; mem_req = run & (count < DEPTH).
- mem_addr = fetch_pc; increments by 1 per accepted byte, wraps modulo 2^ADDR_W.
- inst_valid = count ≥ 1 and (head bit 7 = 0 or count ≥ 2). Outputs combinational from queue head; 0 when inst_valid low.
- Pop on inst handshake: remove inst_bytes bytes, head_pc += inst_bytes (wrap modulo 2^ADDR_W).
- Push and pop in same cycle: count += 1 − inst_bytes; full queue with simultaneous pop does not accept (mem_req already low).
- Redirect (priority over all): count ← 0, pointers reset, fetch_pc ← head_pc ← redirect_pc. Byte acked in the redirect cycle is discarded; instruction handshake in the redirect cycle is void (not consumed; consumer must not act on it).
- Pointer wrap at DEPTH; 2-byte instruction may straddle the wrap point.

## Timing

- Reset values: mem_req 0, mem_addr RESET_PC, inst_valid 0, inst 0, inst_bytes 0, inst_pc RESET_PC, inst_zero_arg 0, inst_one_arg 0.
- First mem_req: cycle 1 after rst_n deasserts.
- Zero-wait memory (mem_ack tied 1): one byte/cycle; 1-byte instruction valid cycle after its byte acks; 2-byte valid cycle after second byte acks.
- Redirect at edge N: mem_addr = redirect_pc and inst_valid = 0 from cycle N+1; mem_req high in N+1.
- Full → pop → mem_req high the following cycle.
- rst_n low mid-transfer: all state cleared immediately, outstanding request dropped, no handshake completes.

## Test plan

- Reset, RESET_PC=0, mem_ack=1, memory 0x01,0x80,0x05, inst_ready=1 → inst 0x0100 bytes 1 pc 0x0000, then inst 0x8005 bytes 2 pc 0x0001, inst_one_arg=1.
- DEPTH=4, inst_ready=0, all bytes 0x00 → after 4 acks mem_req=0, mem_addr=0x0004; one pop → mem_req=1 next cycle, count 3→4.
- Queue holds only 0x88 → inst_valid=0; second byte 0x12 acks → next cycle inst 0x8812, bytes 2.
- Redirect to 0x0040 in a cycle with mem_ack=1 and inst handshake → byte discarded, next cycle mem_addr 0x0040, inst_valid 0; first delivered inst_pc 0x0040.
- RESET_PC=0xFFFF, memory[0xFFFF]=0xC0, [0x0000]=0x10 → inst 0xC010, inst_pc 0xFFFF, mem_addr then 0x0001; DEPTH=2 straddle case assembles correctly.
- rst_n pulsed low while queue holds 3 bytes and mem_req high → outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_if.sv
// Bus bundle between the instruction prefetch unit, program memory and decoder.
// The master modport is the prefetch side; the slave modport is its environment.
interface inst_prefetch_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [15:0]       inst;
  logic [1:0]        inst_bytes;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_zero_arg;
  logic              inst_one_arg;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_bytes, inst_pc,
           inst_zero_arg, inst_one_arg,
    input  mem_ack, mem_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_bytes, inst_pc,
           inst_zero_arg, inst_one_arg,
    output mem_ack, mem_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_prefetch.sv
// Byte-wide instruction prefetch: queues program bytes and assembles 1- or
// 2-byte instructions (head bit 7 selects length) for the decoder.
module inst_prefetch #(
  parameter int                 DEPTH    = 4,
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_prefetch_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]        r_queue [DEPTH];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_fetchPc;
  logic [ADDR_W-1:0] r_headPc;
  logic              r_run;

  logic [7:0]        w_headByte;
  logic [7:0]        w_nextByte;
  logic              w_valid;
  logic              w_memReq;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_popBytes;
  logic [CNT_W-1:0]  w_countNext;

  assign w_headByte = r_queue[r_rdPtr];
  assign w_nextByte = r_queue[r_rdPtr + PTR_W'(1)];
  assign w_valid    = (r_count != '0) && (!w_headByte[7] || (r_count >= CNT_W'(2)));
  assign w_memReq   = r_run && (r_count < CNT_W'(DEPTH));
  assign w_popBytes = w_headByte[7] ? 2'd2 : 2'd1;
  assign w_push     = w_memReq & bus.mem_ack;
  assign w_pop      = w_valid & bus.inst_ready;

  always_comb begin
    w_countNext = r_count + CNT_W'(w_push) - (w_pop ? CNT_W'(w_popBytes) : '0);
  end

  assign bus.mem_req       = w_memReq;
  assign bus.mem_addr      = r_fetchPc;
  assign bus.inst_valid    = w_valid;
  assign bus.inst          = w_valid ? {w_headByte, (w_headByte[7] ? w_nextByte : 8'h00)} : 16'h0000;
  assign bus.inst_bytes    = w_valid ? w_popBytes : 2'd0;
  assign bus.inst_pc       = r_headPc;
  assign bus.inst_zero_arg = w_valid && !w_headByte[7];
  assign bus.inst_one_arg  = w_valid && (w_headByte[7:6] == 2'b10);

  // Queue storage needs no reset: r_count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_queue[r_wrPtr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_fetchPc <= RESET_PC;
      r_headPc  <= RESET_PC;
      r_run     <= 1'b0;
    end else begin
      r_run <= 1'b1;
      // Redirect discards both the byte acked and the instruction handed over this cycle.
      if (bus.redirect) begin
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
        r_count   <= '0;
        r_fetchPc <= bus.redirect_pc;
        r_headPc  <= bus.redirect_pc;
      end else begin
        r_count <= w_countNext;
        if (w_push) begin
          r_wrPtr   <= r_wrPtr + PTR_W'(1);
          r_fetchPc <= r_fetchPc + ADDR_W'(1);
        end
        if (w_pop) begin
          r_rdPtr  <= r_rdPtr + PTR_W'(w_popBytes);
          r_headPc <= r_headPc + ADDR_W'(w_popBytes);
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench: DUT A (DEPTH=4, RESET_PC=0) covers assembly, full queue,
// redirect and async reset; DUT B (DEPTH=2, RESET_PC=0xFFFF) covers address and queue wrap.
module tb_inst_prefetch;
  logic clk;
  logic rstA_n;
  logic rstB_n;
  int   nChecks;
  int   nFails;

  logic [7:0] memA [256];
  logic [7:0] memB [256];

  inst_prefetch_if #(.ADDR_W(16)) ifA ();
  inst_prefetch_if #(.ADDR_W(16)) ifB ();

  inst_prefetch #(.DEPTH(4), .ADDR_W(16), .RESET_PC(16'h0000)) dutA (
    .clk(clk), .rst_n(rstA_n), .bus(ifA)
  );
  inst_prefetch #(.DEPTH(2), .ADDR_W(16), .RESET_PC(16'hFFFF)) dutB (
    .clk(clk), .rst_n(rstB_n), .bus(ifB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb ifA.mem_data = memA[ifA.mem_addr[7:0]];
  always_comb ifB.mem_data = memB[ifB.mem_addr[7:0]];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive DUT A inputs, then advance one rising edge and stop at the falling edge.
  task automatic applyStimulus(input logic ack, input logic ready,
                               input logic redir, input logic [15:0] rpc);
    ifA.mem_ack     = ack;
    ifA.inst_ready  = ready;
    ifA.redirect    = redir;
    ifA.redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stepB();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rstA_n  = 1'b0;
    rstB_n  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 8'h00;
      memB[i] = 8'h00;
    end
    memA[8'h00] = 8'h01; memA[8'h01] = 8'h80; memA[8'h02] = 8'h05;
    memA[8'h30] = 8'h88; memA[8'h31] = 8'h12; memA[8'h32] = 8'h55;
    memA[8'h40] = 8'h7F;
    memB[8'hFF] = 8'hC0; memB[8'h00] = 8'h10; memB[8'h01] = 8'h05;
    memB[8'h02] = 8'h81; memB[8'h03] = 8'h23;
    ifA.mem_ack = 1'b1; ifA.inst_ready = 1'b1; ifA.redirect = 1'b0; ifA.redirect_pc = 16'h0000;
    ifB.mem_ack = 1'b1; ifB.inst_ready = 1'b1; ifB.redirect = 1'b0; ifB.redirect_pc = 16'h0000;

    @(negedge clk);
    checkOutput("rst mem_req",    32'(ifA.mem_req),       32'h0);
    checkOutput("rst mem_addr",   32'(ifA.mem_addr),      32'h0000);
    checkOutput("rst inst_valid", 32'(ifA.inst_valid),    32'h0);
    checkOutput("rst inst",       32'(ifA.inst),          32'h0000);
    checkOutput("rst inst_bytes", 32'(ifA.inst_bytes),    32'h0);
    checkOutput("rst inst_pc",    32'(ifA.inst_pc),       32'h0000);
    checkOutput("rst zero_arg",   32'(ifA.inst_zero_arg), 32'h0);
    checkOutput("rst one_arg",    32'(ifA.inst_one_arg),  32'h0);

    // Zero-wait memory: 0x01 then 0x80,0x05
    rstA_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("first mem_req",  32'(ifA.mem_req),    32'h1);
    checkOutput("first mem_addr", 32'(ifA.mem_addr),   32'h0000);
    checkOutput("first valid",    32'(ifA.inst_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("i0 inst",     32'(ifA.inst),          32'h0100);
    checkOutput("i0 bytes",    32'(ifA.inst_bytes),    32'h1);
    checkOutput("i0 pc",       32'(ifA.inst_pc),       32'h0000);
    checkOutput("i0 zero_arg", 32'(ifA.inst_zero_arg), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("i1 partial valid", 32'(ifA.inst_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("i1 inst",     32'(ifA.inst),          32'h8005);
    checkOutput("i1 bytes",    32'(ifA.inst_bytes),    32'h2);
    checkOutput("i1 pc",       32'(ifA.inst_pc),       32'h0001);
    checkOutput("i1 one_arg",  32'(ifA.inst_one_arg),  32'h1);
    checkOutput("i1 zero_arg", 32'(ifA.inst_zero_arg), 32'h0);

    // Fill the queue with 0x00 bytes while the consumer stalls
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0020);
    checkOutput("redir20 mem_req",  32'(ifA.mem_req),    32'h1);
    checkOutput("redir20 mem_addr", 32'(ifA.mem_addr),   32'h0020);
    checkOutput("redir20 valid",    32'(ifA.inst_valid), 32'h0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("full mem_req",  32'(ifA.mem_req),       32'h0);
    checkOutput("full mem_addr", 32'(ifA.mem_addr),      32'h0024);
    checkOutput("full inst",     32'(ifA.inst),          32'h0000);
    checkOutput("full valid",    32'(ifA.inst_valid),    32'h1);
    checkOutput("full zero_arg", 32'(ifA.inst_zero_arg), 32'h1);
    checkOutput("full pc",       32'(ifA.inst_pc),       32'h0020);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("pop mem_req",  32'(ifA.mem_req),  32'h1);
    checkOutput("pop mem_addr", 32'(ifA.mem_addr), 32'h0024);
    checkOutput("pop pc",       32'(ifA.inst_pc),  32'h0021);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("refill mem_req",  32'(ifA.mem_req),  32'h0);
    checkOutput("refill mem_addr", 32'(ifA.mem_addr), 32'h0025);

    // Lone 0x88 must wait for its second byte
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0030);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("half valid",    32'(ifA.inst_valid), 32'h0);
    checkOutput("half mem_addr", 32'(ifA.mem_addr),   32'h0031);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("half idle valid", 32'(ifA.inst_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("pair inst",    32'(ifA.inst),         32'h8812);
    checkOutput("pair bytes",   32'(ifA.inst_bytes),   32'h2);
    checkOutput("pair pc",      32'(ifA.inst_pc),      32'h0030);
    checkOutput("pair one_arg", 32'(ifA.inst_one_arg), 32'h1);

    // Redirect together with an ack (0x55) and an instruction handshake
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040);
    checkOutput("redir40 mem_addr", 32'(ifA.mem_addr),   32'h0040);
    checkOutput("redir40 mem_req",  32'(ifA.mem_req),    32'h1);
    checkOutput("redir40 valid",    32'(ifA.inst_valid), 32'h0);
    checkOutput("redir40 inst",     32'(ifA.inst),       32'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("after redir inst",  32'(ifA.inst),       32'h7F00);
    checkOutput("after redir pc",    32'(ifA.inst_pc),    32'h0040);
    checkOutput("after redir bytes", 32'(ifA.inst_bytes), 32'h1);

    // Async reset with three bytes queued and a request pending
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0050);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("pre-rst mem_req",  32'(ifA.mem_req),  32'h1);
    checkOutput("pre-rst mem_addr", 32'(ifA.mem_addr), 32'h0053);
    #2 rstA_n = 1'b0;
    #1;
    checkOutput("async mem_req",    32'(ifA.mem_req),       32'h0);
    checkOutput("async mem_addr",   32'(ifA.mem_addr),      32'h0000);
    checkOutput("async valid",      32'(ifA.inst_valid),    32'h0);
    checkOutput("async inst",       32'(ifA.inst),          32'h0000);
    checkOutput("async bytes",      32'(ifA.inst_bytes),    32'h0);
    checkOutput("async pc",         32'(ifA.inst_pc),       32'h0000);
    checkOutput("async zero_arg",   32'(ifA.inst_zero_arg), 32'h0);
    @(negedge clk);
    rstA_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("restart mem_req",  32'(ifA.mem_req),  32'h1);
    checkOutput("restart mem_addr", 32'(ifA.mem_addr), 32'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("restart inst", 32'(ifA.inst),    32'h0100);
    checkOutput("restart pc",   32'(ifA.inst_pc), 32'h0000);

    // DUT B: address wrap at 0xFFFF and an instruction straddling the queue wrap
    checkOutput("B rst mem_addr", 32'(ifB.mem_addr), 32'hFFFF);
    checkOutput("B rst inst_pc",  32'(ifB.inst_pc),  32'hFFFF);
    checkOutput("B rst mem_req",  32'(ifB.mem_req),  32'h0);
    rstB_n = 1'b1;
    stepB();
    checkOutput("B first mem_req",  32'(ifB.mem_req),  32'h1);
    checkOutput("B first mem_addr", 32'(ifB.mem_addr), 32'hFFFF);
    stepB();
    checkOutput("B wrap valid",    32'(ifB.inst_valid), 32'h0);
    checkOutput("B wrap mem_addr", 32'(ifB.mem_addr),   32'h0000);
    stepB();
    checkOutput("B c010 inst",     32'(ifB.inst),       32'hC010);
    checkOutput("B c010 pc",       32'(ifB.inst_pc),    32'hFFFF);
    checkOutput("B c010 bytes",    32'(ifB.inst_bytes), 32'h2);
    checkOutput("B full mem_req",  32'(ifB.mem_req),    32'h0);
    checkOutput("B full mem_addr", 32'(ifB.mem_addr),   32'h0001);
    stepB();
    checkOutput("B empty mem_req", 32'(ifB.mem_req),    32'h1);
    checkOutput("B empty valid",   32'(ifB.inst_valid), 32'h0);
    stepB();
    checkOutput("B 0500 inst", 32'(ifB.inst),    32'h0500);
    checkOutput("B 0500 pc",   32'(ifB.inst_pc), 32'h0001);
    stepB();
    checkOutput("B half valid", 32'(ifB.inst_valid), 32'h0);
    stepB();
    checkOutput("B straddle inst",  32'(ifB.inst),       32'h8123);
    checkOutput("B straddle pc",    32'(ifB.inst_pc),    32'h0002);
    checkOutput("B straddle bytes", 32'(ifB.inst_bytes), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
